// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants, request type and FSM encoding for the register-file
// write-back arbiter.
package regfile_wb_arbiter_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } rf_wr_req_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } arb_state_e;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] one;
    one     = '0;
    one[rd] = 1'b1;
    return one;
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between write-back stage, MDU, register file and hazard unit.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  stall_o;
  logic                  mdu_valid;
  logic                  mdu_ready;
  logic [REG_ADDR_W-1:0] mdu_rd;
  logic [XLEN-1:0]       mdu_data;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]       rf_wdata;
  logic [NUM_REGS-1:0]   pend_mask;

  modport master (
    output wb_valid, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
    input  stall_o, mdu_ready, rf_we, rf_waddr, rf_wdata, pend_mask
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
    output stall_o, mdu_ready, rf_we, rf_waddr, rf_wdata, pend_mask
  );
endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// MDU result FIFO; exposes per-entry valid/rd so the top can build the
// pending-destination mask.
module rf_wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  rf_wr_req_t                         push_req,
  input  logic                               pop,
  output rf_wr_req_t                         head,
  output logic                               full,
  output logic                               empty,
  output logic [DEPTH-1:0]                   ent_vld,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]   ent_rd
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  rf_wr_req_t     mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign ent_rd[g] = mem[g].rd;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_req;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      for (int i = 0; i < DEPTH; i++) begin
        if (pop_ok  && rd_ptr == PW'(i)) ent_vld[i] <= 1'b0;
        if (push_ok && wr_ptr == PW'(i)) ent_vld[i] <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single register-file write port shared by the pipeline write-back stage
// and buffered MDU results, with a starvation-forced one-cycle stall.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e                    state_q, state_d;
  logic [CNT_W-1:0]              starve_q, starve_d;
  rf_wr_req_t                    wb_req, mdu_req, head, wr_req;
  logic                          full, empty, fifo_push, fifo_pop, wb_win, wr_en;
  logic [DEPTH-1:0]              ent_vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
  logic [NUM_REGS-1:0]           mask;
  logic                          we_q;
  logic [REG_ADDR_W-1:0]         waddr_q;
  logic [XLEN-1:0]               wdata_q;

  assign wb_req    = '{rd: bus.wb_rd,  data: bus.wb_data};
  assign mdu_req   = '{rd: bus.mdu_rd, data: bus.mdu_data};
  assign bus.mdu_ready = !full;
  // x0 results are swallowed here so they never occupy a FIFO slot.
  assign fifo_push = bus.mdu_valid && !full && (bus.mdu_rd != '0);
  assign bus.stall_o = (state_q == ST_FORCE);

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_req (mdu_req),
    .pop      (fifo_pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .ent_vld  (ent_vld),
    .ent_rd   (ent_rd)
  );

  always_comb begin
    state_d  = ST_NORMAL;
    starve_d = '0;
    wb_win   = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      ST_FORCE: fifo_pop = !empty;
      default: begin
        wb_win   = bus.wb_valid && (bus.wb_rd != '0);
        fifo_pop = !wb_win && !empty;
        if (!empty && !fifo_pop) starve_d = starve_q + 1'b1;
        if (starve_d == CNT_W'(STARVE_LIMIT)) state_d = ST_FORCE;
      end
    endcase
    wr_en  = wb_win || fifo_pop;
    wr_req = wb_win ? wb_req : head;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_NORMAL;
      starve_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      we_q     <= wr_en;
      if (wr_en) begin
        waddr_q <= wr_req.rd;
        wdata_q <= wr_req.data;
      end
    end
  end

  assign bus.rf_we    = we_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;

  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld[i]) mask = mask | rd_onehot(ent_rd[i]);
  end

  assign bus.pend_mask = {mask[NUM_REGS-1:1], 1'b0};
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: queue-based reference model predicts each register-file
// write; a posedge monitor pops and compares.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  rf_wr_req_t sb[$];   // writes expected on the coming edge
  rf_wr_req_t mq[$];   // model of buffered MDU results
  int         head_wait;
  bit         force_nxt;
  bit         held;
  logic [4:0] h_rd;
  logic [31:0] h_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  task automatic drive_idle();
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.mdu_valid = 1'b0; bus.mdu_rd = '0; bus.mdu_data = '0;
  endtask

  // One cycle: check visible state, drive inputs, advance the model.
  task automatic step(input bit wv, input logic [4:0] wrd, input logic [31:0] wd,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    rf_wr_req_t e;
    bit nonempty, was_full, popped;
    @(negedge clk);
    chk("stall_o",   {31'b0, bus.stall_o},   {31'b0, force_nxt});
    chk("mdu_ready", {31'b0, bus.mdu_ready}, {31'b0, mq.size() < DEPTH});
    chk("pend_mask", bus.pend_mask, model_mask());
    if (held) begin
      wv = 1'b1; wrd = h_rd; wd = h_data;
    end
    bus.wb_valid = wv; bus.wb_rd = wrd; bus.wb_data = wd;
    bus.mdu_valid = mv; bus.mdu_rd = mrd; bus.mdu_data = md;

    nonempty = (mq.size() != 0);
    was_full = (mq.size() == DEPTH);
    popped   = 1'b0;
    held     = 1'b0;
    if (force_nxt) begin
      sb.push_back(mq.pop_front());
      force_nxt = 1'b0;
      head_wait = 0;
      if (wv) begin held = 1'b1; h_rd = wrd; h_data = wd; end
    end else begin
      if (wv && wrd != 0) begin
        e.rd = wrd; e.data = wd; sb.push_back(e);
      end else if (nonempty) begin
        sb.push_back(mq.pop_front()); popped = 1'b1;
      end
      if (nonempty && !popped) begin
        head_wait++;
        if (head_wait == LIMIT) force_nxt = 1'b1;
      end else head_wait = 0;
    end
    if (mv && !was_full && mrd != 0) begin
      e.rd = mrd; e.data = md; mq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    #1;
    chk("rst_rf_we",     {31'b0, bus.rf_we},     32'd0);
    chk("rst_pend_mask", bus.pend_mask,          32'd0);
    chk("rst_stall_o",   {31'b0, bus.stall_o},   32'd0);
    chk("rst_mdu_ready", {31'b0, bus.mdu_ready}, 32'd1);
    mq.delete(); sb.delete();
    head_wait = 0; force_nxt = 1'b0; held = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  always @(posedge clk) begin
    rf_wr_req_t e;
    #1;
    if (rst) begin
      checks++;
      if (bus.rf_we) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got x%0d=%h expected no write", bus.rf_waddr, bus.rf_wdata);
        end else begin
          e = sb.pop_front();
          if (bus.rf_waddr !== e.rd || bus.rf_wdata !== e.data) begin
            errors++;
            $display("FAIL write: got x%0d=%h expected x%0d=%h", bus.rf_waddr, bus.rf_wdata, e.rd, e.data);
          end
        end
      end else if (sb.size() != 0) begin
        e = sb.pop_front();
        errors++;
        $display("FAIL missing_write: got rf_we=0 expected x%0d=%h", e.rd, e.data);
      end
    end
  end

  initial begin
    int busy;
    drive_idle();
    head_wait = 0; force_nxt = 1'b0; held = 1'b0;
    #12;
    chk("por_rf_we",     {31'b0, bus.rf_we},     32'd0);
    chk("por_rf_waddr",  {27'b0, bus.rf_waddr},  32'd0);
    chk("por_rf_wdata",  bus.rf_wdata,           32'd0);
    chk("por_pend_mask", bus.pend_mask,          32'd0);
    chk("por_mdu_ready", {31'b0, bus.mdu_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    idle(10);
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    step(1, 5'd0, 32'h0000_0001, 0, 0, 0);
    idle(2);

    step(0, 0, 0, 1, 5'd7, 32'h12);
    idle(4);

    // Fill the FIFO while the pipeline keeps the port busy to force starvation.
    for (int i = 0; i < 4; i++) step(1, 5'd10, 32'hA000 + i, 1, 5'(8 + i), 32'h100 + i);
    for (int i = 0; i < 40; i++) step(1, 5'd10, 32'hB000 + i, 0, 0, 0);
    idle(6);

    step(1, 5'd3, 32'h33, 1, 5'd20, 32'h200);
    step(1, 5'd3, 32'h34, 1, 5'd21, 32'h201);
    step(0, 0, 0, 1, 5'd22, 32'h202);
    step(0, 0, 0, 1, 5'd23, 32'h203);
    idle(5);

    for (int i = 0; i < 3; i++) step(1, 5'd4, 32'hC0 + i, 1, 5'(12 + i), 32'h300 + i);
    do_reset();
    idle(6);

    for (int k = 0; k < 2000; k++) begin
      busy = ((k / 250) % 2) ? 95 : 50;
      if (k == 1000) do_reset();
      step($urandom_range(0, 99) < busy, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 99) < 40,   5'($urandom_range(0, 31)), $urandom);
    end
    idle(3 * DEPTH * (LIMIT + 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
